// File: rtl/cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_step_ctrl
//
// Generates a single-cycle clock-enable pulse (cpuEn) for a CPU core that runs
// on clk.  The core is never clocked from a derived clock.  Three modes:
//   HALT  (00) : one enable per debounced press of the step button
//   RUN   (01) : free-running enables at a rate picked by rateSel
//   BURST (10) : burstLen enables at the rateSel rate, then back to HALT
//
// Optional feature (build macro CPU_STEP_BREAKPOINT_EN):
//   In RUN/BURST an enable that would fire while bpEn is high and
//   pcAddr == bpAddr is dropped, the block halts and bpHit is set.  bpHit
//   clears when the block leaves HALT or takes a step.  The first enable after
//   leaving HALT skips the compare so the CPU can resume from the breakpoint.
//   Without the macro bpHit is tied low and bpEn/bpAddr/pcAddr are ignored.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : synchronous, active-high reset
//   stepBtn    : raw asynchronous step button, active-low
//   runReq     : one-cycle request HALT -> RUN
//   burstReq   : one-cycle request HALT -> BURST (ignored if burstLen == 0)
//   haltReq    : one-cycle request RUN/BURST -> HALT (wins over other requests)
//   rateSel    : run-rate select; all-ones means one enable per clk
//   burstLen   : enables per burst
//   bpEn       : breakpoint enable
//   bpAddr     : breakpoint address
//   pcAddr     : current CPU program address
//   cpuEn      : registered one-cycle enable pulse
//   state      : current mode, HALT=00 RUN=01 BURST=10
//   halted     : high while in HALT
//   bpHit      : sticky breakpoint flag
//   stepCount  : count of cpuEn pulses, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module cpu_step_ctrl #(
    parameter int BASE_DIV   = 1200000,
    parameter int RATE_SHIFT = 1,
    parameter int RSEL_W     = 2,
    parameter int PC_W       = 12,
    parameter int BURST_W    = 8,
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 120000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stepBtn,
    input  logic               runReq,
    input  logic               burstReq,
    input  logic               haltReq,
    input  logic [RSEL_W-1:0]  rateSel,
    input  logic [BURST_W-1:0] burstLen,
    input  logic               bpEn,
    input  logic [PC_W-1:0]    bpAddr,
    input  logic [PC_W-1:0]    pcAddr,
    output logic               cpuEn,
    output logic [1:0]         state,
    output logic               halted,
    output logic               bpHit,
    output logic [CNT_W-1:0]   stepCount
);

    // The tick counter never exceeds BASE_DIV-1, the debounce counter never
    // exceeds DEB_CYCLES-1.
    localparam int DIV_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_BURST = 2'b10
    } stateT;

    stateT              stateQ;
    logic [BURST_W-1:0] remaining;
    logic [DIV_W-1:0]   tickCnt;
    logic [RSEL_W-1:0]  rateSelQ;

    // -----------------------------------------------------------------------
    // Step button: 2-flop synchroniser, then a stability-window debouncer.
    // Flops reset to 1 so a released button never looks like a press.
    // -----------------------------------------------------------------------
    logic             sync1;
    logic             sync2;
    logic             debLvl;
    logic [DEB_W-1:0] debCnt;
    logic             stepEvt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            debLvl  <= 1'b1;
            debCnt  <= '0;
            stepEvt <= 1'b0;
        end else begin
            sync1   <= stepBtn;
            sync2   <= sync1;
            stepEvt <= 1'b0;
            if (sync2 == debLvl) begin
                // Any bounce back to the current level restarts the window.
                debCnt <= '0;
            end else if (debCnt == DEB_W'(DEB_CYCLES - 1)) begin
                // DEB_CYCLES consecutive differing samples: accept the level.
                debLvl  <= sync2;
                debCnt  <= '0;
                // Event only on press (debounced 1 -> 0).
                stepEvt <= debLvl;
            end else begin
                debCnt <= debCnt + DEB_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Rate divisor.  Large shifts saturate at a divisor of 1.
    // -----------------------------------------------------------------------
    logic [31:0]      divFull;
    logic [DIV_W-1:0] divM1;
    logic             tick;

    always_comb begin
        divFull = 32'(BASE_DIV) >> (RATE_SHIFT * int'(rateSel));
        if ((rateSel == '1) || (divFull == 32'd0)) begin
            divFull = 32'd1;
        end
    end

    assign divM1 = DIV_W'(divFull - 32'd1);
    assign tick  = (stateQ != S_HALT) && (tickCnt == divM1);

    // -----------------------------------------------------------------------
    // Request decode.  haltReq beats everything, runReq beats burstReq.
    // -----------------------------------------------------------------------
    logic enterRun;
    logic enterBurst;

    assign enterRun   = (stateQ == S_HALT) && !haltReq && runReq;
    assign enterBurst = (stateQ == S_HALT) && !haltReq && !runReq &&
                        burstReq && (burstLen != '0);

    // Would-be enable before the breakpoint filter.  haltReq drops any enable
    // in the cycle it is sampled; a finished burst issues nothing more.
    logic wouldEn;
    logic bpStop;
    logic nextEn;

    always_comb begin
        wouldEn = 1'b0;
        case (stateQ)
            S_HALT:  wouldEn = stepEvt;
            S_RUN:   wouldEn = tick && !haltReq;
            S_BURST: wouldEn = tick && !haltReq && (remaining != '0);
            default: wouldEn = 1'b0;
        endcase
    end

    assign nextEn = wouldEn && !bpStop;

    // -----------------------------------------------------------------------
    // Mode FSM, enable pulse, step counter, tick counter.
    // stepCount moves on the same edge that raises cpuEn, so a CPU sampling
    // stepCount sees the count including the pulse it is executing.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= S_HALT;
            cpuEn     <= 1'b0;
            stepCount <= '0;
            remaining <= '0;
            tickCnt   <= '0;
            rateSelQ  <= '0;
        end else begin
            cpuEn     <= nextEn;
            stepCount <= stepCount + CNT_W'(nextEn);
            rateSelQ  <= rateSel;

            // Held at 0 in HALT, so entry to RUN/BURST always starts from 0
            // and the first enable lands exactly one divisor after entry.
            if ((stateQ == S_HALT) || (rateSel != rateSelQ) || tick) begin
                tickCnt <= '0;
            end else begin
                tickCnt <= tickCnt + DIV_W'(1);
            end

            case (stateQ)
                S_HALT: begin
                    if (enterRun) begin
                        stateQ <= S_RUN;
                    end else if (enterBurst) begin
                        stateQ    <= S_BURST;
                        remaining <= burstLen;
                    end
                end
                S_RUN: begin
                    if (haltReq || bpStop) begin
                        stateQ <= S_HALT;
                    end
                end
                S_BURST: begin
                    // remaining==0 means the last pulse went out last cycle.
                    if (haltReq || bpStop || (remaining == '0)) begin
                        stateQ    <= S_HALT;
                        remaining <= '0;
                    end else if (nextEn) begin
                        remaining <= remaining - BURST_W'(1);
                    end
                end
                default: begin
                    stateQ    <= S_HALT;
                    remaining <= '0;
                end
            endcase
        end
    end

    assign state  = stateQ;
    assign halted = (stateQ == S_HALT);

    // -----------------------------------------------------------------------
    // Breakpoint logic
    // -----------------------------------------------------------------------
`ifdef CPU_STEP_BREAKPOINT_EN
    // Set on leaving HALT, cleared by the first enable that goes out, so the
    // CPU can resume while still sitting on the breakpoint address.
    logic skipCmp;

    assign bpStop = (stateQ != S_HALT) && wouldEn && !skipCmp &&
                    bpEn && (pcAddr == bpAddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            skipCmp <= 1'b0;
            bpHit   <= 1'b0;
        end else begin
            if (enterRun || enterBurst) begin
                skipCmp <= 1'b1;
            end else if (nextEn) begin
                skipCmp <= 1'b0;
            end

            if (bpStop) begin
                bpHit <= 1'b1;
            end else if (enterRun || enterBurst ||
                         ((stateQ == S_HALT) && stepEvt)) begin
                bpHit <= 1'b0;
            end
        end
    end
`else
    logic unusedBp;

    assign bpStop   = 1'b0;
    assign bpHit    = 1'b0;
    assign unusedBp = ^{bpEn, bpAddr, pcAddr};
`endif

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter BASE_DIV, default 1200000, meaning the clk cycles per enable at rateSel=0 (10 Hz at 12 MHz).
REQ-002 SHALL have parameter RATE_SHIFT, default 1, meaning the divisor right-shift applied per rateSel step.
REQ-003 SHALL have parameter RSEL_W, default 2, meaning the rateSel width.
REQ-004 SHALL have parameter PC_W, default 12, meaning the program-address width.
REQ-005 SHALL have parameter BURST_W, default 8, meaning the burst-length width.
REQ-006 SHALL have parameter CNT_W, default 16, meaning the stepCount width.
REQ-007 SHALL have parameter DEB_CYCLES, default 120000, meaning the debounce stability window in clk cycles.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-010 SHALL have port stepBtn, input, 1 bit: raw asynchronous step button, active-low.
REQ-011 SHALL have port runReq, input, 1 bit: single-cycle request to enter RUN.
REQ-012 SHALL have port burstReq, input, 1 bit: single-cycle request to enter BURST.
REQ-013 SHALL have port haltReq, input, 1 bit: single-cycle request to enter HALT.
REQ-014 SHALL have port rateSel, input, RSEL_W bits: run-rate select.
REQ-015 SHALL have port burstLen, input, BURST_W bits: number of enables per burst.
REQ-016 SHALL have ports bpEn (input, 1 bit, breakpoint enable) and bpAddr (input, PC_W bits, breakpoint address).
REQ-017 SHALL have port pcAddr, input, PC_W bits: current CPU program address.
REQ-018 SHALL have port cpuEn, output, 1 bit: one-cycle CPU clock-enable pulse; CPU uses clk plus cpuEn, never a derived clock.
REQ-019 SHALL have port state, output, 2 bits: HALT=00, RUN=01, BURST=10 (11 unused).
REQ-020 SHALL have ports halted (output, 1 bit, high when state==HALT) and bpHit (output, 1 bit, sticky breakpoint flag).
REQ-021 SHALL have port stepCount, output, CNT_W bits: running count of cpuEn pulses.

Function
REQ-022 SHALL synchronise stepBtn through 2 flops, then update the debounced level only after the synchronised value has been stable for DEB_CYCLES consecutive cycles; a 1->0 transition of the debounced level SHALL produce a one-cycle stepEvt.
REQ-023 SHALL use divisor rateSel==all-ones ? 1 : BASE_DIV>>(RATE_SHIFT*rateSel) (minimum 1); tick SHALL assert when the counter reaches divisor-1, then the counter reloads 0.
REQ-024 SHALL clear the tick counter to 0 whenever rateSel changes and on entry to RUN or BURST, so the first enable arrives exactly divisor cycles after entry.
REQ-025 In HALT, cpuEn SHALL equal stepEvt (registered, 1 cycle later); tick SHALL be ignored.
REQ-026 In RUN, cpuEn SHALL equal tick; stepEvt SHALL be ignored.
REQ-027 BURST SHALL load remaining=burstLen on entry, issue cpuEn on tick, decrement remaining per cpuEn, and go to HALT in the cycle after the pulse that makes remaining 0.
REQ-028 Transitions: runReq in HALT -> RUN; burstReq in HALT with burstLen!=0 -> BURST; burstReq with burstLen==0 is ignored; runReq and burstReq outside HALT are ignored.
REQ-029 haltReq in RUN or BURST -> HALT next cycle, and SHALL suppress any cpuEn in the cycle it is sampled high.
REQ-030 haltReq SHALL win over runReq or burstReq in the same cycle; runReq SHALL win over burstReq.
REQ-031 stepCount SHALL increment on every cpuEn and wrap modulo 2^CNT_W.

Reset
REQ-032 When rst is high at a clk edge, all of the following SHALL apply next cycle regardless of state: state=HALT, cpuEn=0, bpHit=0, stepCount=0, remaining=0, tick counter=0, debounced level=1 (released), sync flops=1.
REQ-033 Reset mid-BURST or mid-RUN SHALL discard remaining and produce no further cpuEn until a new request arrives.

Configuration
REQ-034 With CPU_STEP_BREAKPOINT_EN defined, in RUN/BURST a would-be cpuEn while bpEn==1 and pcAddr==bpAddr SHALL be suppressed, the block SHALL enter HALT, and bpHit SHALL set.
REQ-035 With CPU_STEP_BREAKPOINT_EN defined, bpHit SHALL clear on runReq, burstReq or stepEvt accepted in HALT, and the first enable after leaving HALT SHALL skip the compare so resume is possible at the breakpoint address.
REQ-036 Without CPU_STEP_BREAKPOINT_EN, bpHit SHALL be constant 0, and bpEn, bpAddr and pcAddr SHALL have no effect.

Verification (BASE_DIV=8, RATE_SHIFT=1, RSEL_W=2, DEB_CYCLES=4)
REQ-037 Step: stepBtn low 10 cycles in HALT -> exactly one cpuEn, stepCount=1; a 2-cycle low glitch -> no cpuEn.
REQ-038 Rate: RUN with rateSel=0/1/2/3 -> cpuEn period 8/4/2/1 cycles; a rateSel change mid-run restarts the count.
REQ-039 Burst: burstLen=5, rateSel=3 -> exactly 5 cpuEn, then state=00, stepCount=5; burstLen=0 -> stays HALT.
REQ-040 Breakpoint (macro on): pcAddr=stepCount, bpAddr=0x005, RUN at full speed -> 5 pulses, then HALT with bpHit=1; runReq -> bpHit=0 and the next pulse is issued at pcAddr 0x005.
REQ-041 Conflicts: runReq+haltReq in the same cycle -> stays HALT; rst during BURST with remaining=3 -> state=00, stepCount=0, no cpuEn.
REQ-042 Macro off: the same stimulus as REQ-040 -> no halt, bpHit stays 0.
